// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared types, defaults and helpers for the configuration chain loader
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_LOAD,
        ST_DONE
    } state_t;

    localparam int                    DEF_MARK_W = 8;
    localparam logic [DEF_MARK_W-1:0] DEF_MARKER = 8'hA5;

    // Number of meaningful MSBs in the final stream word of a load.
    function automatic int last_word_bits(input int chain_len, input int word_w);
        int rem;
        rem = chain_len % word_w;
        return (rem == 0) ? word_w : rem;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// rtl/ccff_word_serializer.sv - word buffer that feeds payload bits MSB-first with zero-bubble refill
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_active,
    input  logic              i_valid,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_bit_valid,
    output logic              o_bit
);

    localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
    localparam int CNT_W     = $clog2(WORD_W + 1);
    localparam int WCNT_W    = $clog2(NUM_WORDS + 1);

    localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(LAST_BITS);
    localparam logic [WCNT_W-1:0] NW_C   = WCNT_W'(NUM_WORDS);

    logic [WORD_W-1:0] r_buf;
    logic [CNT_W-1:0]  r_cnt;
    logic [WCNT_W-1:0] r_words;

    logic              w_empty;
    logic              w_accept;
    logic [CNT_W-1:0]  w_new_cnt;

    assign w_empty   = (r_cnt == '0);
    assign w_new_cnt = (r_words == NW_C - WCNT_W'(1)) ? LAST_C : FULL_C;

    // Ready when the buffer is empty or draining its last bit, and words are still owed.
    // An accepted word into an empty buffer shifts its MSB in the same cycle (cut-through).
    always_comb begin
        o_ready     = i_active && (w_empty || (r_cnt == CNT_W'(1))) && (r_words < NW_C);
        w_accept    = o_ready && i_valid;
        o_bit_valid = i_active && (!w_empty || w_accept);
        o_bit       = w_empty ? i_data[WORD_W-1] : r_buf[WORD_W-1];
    end

    // Buffer, valid-bit count and accepted-word count; the final word is truncated via its count.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_words <= '0;
        end else if (i_active) begin
            if (w_accept) begin
                r_words <= r_words + WCNT_W'(1);
                if (w_empty) begin
                    r_buf <= i_data << 1;
                    r_cnt <= w_new_cnt - CNT_W'(1);
                end else begin
                    r_buf <= i_data;
                    r_cnt <= w_new_cnt;
                end
            end else if (!w_empty) begin
                r_buf <= r_buf << 1;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - marker-prefixed bitstream loader and tail checker for the CCFF chain
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int               CHAIN_LEN = 1024,
    parameter int               WORD_W    = 8,
    parameter int               MARK_W    = DEF_MARK_W,
    parameter logic [MARK_W-1:0] MARKER   = MARK_W'(DEF_MARKER)
) (
    input  logic                                   prog_clk,
    input  logic                                   prog_reset,
    input  logic                                   start,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [WORD_W-1:0]                      s_data,
    output logic                                   cfg_head,
    output logic                                   cfg_shift_en,
    input  logic                                   cfg_tail,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   marker_err,
    output logic [$clog2(CHAIN_LEN+MARK_W+1)-1:0]  bit_count
);

    localparam int BC_W = $clog2(CHAIN_LEN + MARK_W + 1);
    localparam int MI_W = (MARK_W > 1) ? $clog2(MARK_W) : 1;

    localparam logic [BC_W-1:0] MARK_LAST_C  = BC_W'(MARK_W - 1);
    localparam logic [BC_W-1:0] TOTAL_LAST_C = BC_W'(CHAIN_LEN + MARK_W - 1);
    localparam logic [BC_W-1:0] CHAIN_LEN_C  = BC_W'(CHAIN_LEN);
    localparam logic [MI_W-1:0] MARK_TOP_C   = MI_W'(MARK_W - 1);

    state_t            r_state;
    state_t            w_next;
    logic [BC_W-1:0]   r_bit_count;
    logic              r_marker_err;
    logic              r_last_head;

    logic              w_start;
    logic              w_active;
    logic              w_shift_en;
    logic              w_head;
    logic              w_ser_ready;
    logic              w_ser_valid;
    logic              w_ser_bit;
    logic [MI_W-1:0]   w_mark_idx;
    logic [MI_W-1:0]   w_tail_idx;
    logic              w_tail_win;

    assign w_start    = start && (r_state == ST_IDLE);
    assign w_active   = (r_state == ST_LOAD);
    assign w_mark_idx = MARK_TOP_C - MI_W'(r_bit_count);
    assign w_tail_idx = MARK_TOP_C - MI_W'(r_bit_count - CHAIN_LEN_C);
    assign w_tail_win = (r_bit_count >= CHAIN_LEN_C);

    ccff_word_serializer #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) u_serializer (
        .i_clk       (prog_clk),
        .i_reset     (prog_reset),
        .i_clear     (w_start),
        .i_active    (w_active),
        .i_valid     (s_valid),
        .i_data      (s_data),
        .o_ready     (w_ser_ready),
        .o_bit_valid (w_ser_valid),
        .o_bit       (w_ser_bit)
    );

    // State register.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, chain head/shift control and status flags.
    always_comb begin
        w_next     = r_state;
        w_shift_en = 1'b0;
        w_head     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_MARK;
            end
            ST_MARK: begin
                busy       = 1'b1;
                w_shift_en = 1'b1;
                w_head     = MARKER[w_mark_idx];
                if (r_bit_count == MARK_LAST_C) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy       = 1'b1;
                w_shift_en = w_ser_valid;
                w_head     = w_ser_valid ? w_ser_bit : r_last_head;
                if (w_ser_valid && (r_bit_count == TOTAL_LAST_C)) w_next = ST_DONE;
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Shift counter, held head bit for stalls, and sticky tail-marker comparison.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_bit_count  <= '0;
            r_marker_err <= 1'b0;
            r_last_head  <= 1'b0;
        end else if (w_start) begin
            r_bit_count  <= '0;
            r_marker_err <= 1'b0;
        end else if (w_shift_en) begin
            r_bit_count <= r_bit_count + BC_W'(1);
            r_last_head <= w_head;
            if (w_tail_win && (cfg_tail != MARKER[w_tail_idx])) begin
                r_marker_err <= 1'b1;
            end
        end
    end

    assign s_ready      = w_ser_ready;
    assign cfg_head     = w_head;
    assign cfg_shift_en = w_shift_en;
    assign marker_err   = r_marker_err;
    assign bit_count    = r_bit_count;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb/tb_ccff_bitstream_loader.sv - directed self-checking bench with a 20-flop chain model
module tb_ccff_bitstream_loader;

    logic        prog_clk   = 1'b0;
    logic        prog_reset = 1'b1;
    logic        start      = 1'b0;
    logic        s_valid    = 1'b0;
    logic [7:0]  s_data     = 8'h00;
    logic        s_ready;
    logic        cfg_head;
    logic        cfg_shift_en;
    logic        cfg_tail;
    logic        busy;
    logic        done;
    logic        marker_err;
    logic [4:0]  bit_count;

    logic [19:0] chain = 20'h0;
    logic [19:0] chain_next;
    logic        inv   = 1'b0;

    int          checks = 0;
    int          errors = 0;

    logic [7:0]  words [3] = '{8'h12, 8'h34, 8'h5F};

    ccff_bitstream_loader #(
        .CHAIN_LEN (20),
        .WORD_W    (8),
        .MARK_W    (8),
        .MARKER    (8'hA5)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .start        (start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .cfg_head     (cfg_head),
        .cfg_shift_en (cfg_shift_en),
        .cfg_tail     (cfg_tail),
        .busy         (busy),
        .done         (done),
        .marker_err   (marker_err),
        .bit_count    (bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: chain[0] is the head flop, chain[19] the tail; optional inverter after flop 9.
    always_comb begin
        chain_next = {chain[18:0], cfg_head};
        if (inv) chain_next[10] = ~chain[9];
    end

    always @(posedge prog_clk) begin
        if (cfg_shift_en) chain <= chain_next;
    end

    assign cfg_tail = chain[19];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One load: cycle 1 is the first cycle after the start edge. Optional stream gap,
    // start re-pulse and reset injection at given cycles (0 = none).
    task automatic run_load(input int gap_from, input int gap_len, input int start_at,
                            input int rst_at, output int done_cyc, output int shifts,
                            output int pulses, output logic err_c1, output logic err_done,
                            output logic [4:0] bc_done);
        int widx;
        widx     = 0;
        done_cyc = 0;
        shifts   = 0;
        pulses   = 0;
        err_c1   = 1'b0;
        err_done = 1'b0;
        bc_done  = 5'd0;
        start    = 1'b1;
        s_valid  = 1'b0;
        @(posedge prog_clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            start      = (cyc == start_at);
            prog_reset = (cyc == rst_at);
            s_valid    = (widx < 3) && !((cyc >= gap_from) && (cyc < gap_from + gap_len));
            s_data     = (widx < 3) ? words[widx] : 8'h00;
            @(negedge prog_clk);
            if (cyc == 1) err_c1 = marker_err;
            if (cyc == rst_at) bc_done = bit_count;
            if (cyc <= 8) chk("mark_no_ready", {31'd0, s_ready}, 32'd0);
            if (gap_len == 0 && rst_at == 0 && cyc <= 29)
                chk("bit_count_track", {27'd0, bit_count}, cyc - 1);
            if (gap_len > 0 && cyc >= 17 && cyc <= 19)
                chk("gap_stall", {31'd0, cfg_shift_en}, 32'd0);
            if (widx == 3) chk("ready_after_last", {31'd0, s_ready}, 32'd0);
            if (done_cyc != 0) begin
                chk("hold_bit_count", {27'd0, bit_count}, 32'd28);
                chk("idle_not_busy", {31'd0, busy}, 32'd0);
            end
            if (cfg_shift_en) shifts++;
            if (done) begin
                pulses++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    err_done = marker_err;
                    bc_done  = bit_count;
                end
            end
            if (s_valid && s_ready) widx++;
            @(posedge prog_clk); #1;
            if (cyc == rst_at) break;
            if (done_cyc != 0 && cyc >= done_cyc + 2) break;
        end
        start      = 1'b0;
        prog_reset = 1'b0;
        s_valid    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"},    {31'd0, s_ready},      32'd0);
        chk({tag, "_cfg_head"},   {31'd0, cfg_head},     32'd0);
        chk({tag, "_shift_en"},   {31'd0, cfg_shift_en}, 32'd0);
        chk({tag, "_busy"},       {31'd0, busy},         32'd0);
        chk({tag, "_done"},       {31'd0, done},         32'd0);
        chk({tag, "_marker_err"}, {31'd0, marker_err},   32'd0);
        chk({tag, "_bit_count"},  {27'd0, bit_count},    32'd0);
    endtask

    int          dc;
    int          sh;
    int          pl;
    logic        e1;
    logic        ed;
    logic [4:0]  bcd;

    initial begin
        // Reset and idle behaviour
        prog_reset = 1'b1;
        repeat (2) @(posedge prog_clk);
        #1;
        prog_reset = 1'b0;
        @(negedge prog_clk);
        check_all_zero("reset");
        s_valid = 1'b1;
        s_data  = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge prog_clk);
            chk("idle_s_ready", {31'd0, s_ready}, 32'd0);
            chk("idle_shift_en", {31'd0, cfg_shift_en}, 32'd0);
            chk("idle_bit_count", {27'd0, bit_count}, 32'd0);
        end
        @(posedge prog_clk); #1;
        s_valid = 1'b0;

        // Ungapped load
        run_load(0, 0, 0, 0, dc, sh, pl, e1, ed, bcd);
        chk("plain_done_cycle", dc, 32'd29);
        chk("plain_shifts", sh, 32'd28);
        chk("plain_pulses", pl, 32'd1);
        chk("plain_marker_err", {31'd0, ed}, 32'd0);
        chk("plain_bit_count", {27'd0, bcd}, 32'd28);
        chk("plain_chain", {12'd0, chain}, 32'h12345);

        // Three starved cycles before the second word
        run_load(16, 4, 0, 0, dc, sh, pl, e1, ed, bcd);
        chk("gap_done_cycle", dc, 32'd32);
        chk("gap_shifts", sh, 32'd28);
        chk("gap_pulses", pl, 32'd1);
        chk("gap_chain", {12'd0, chain}, 32'h12345);

        // Corrupted chain trips the marker check; the next start clears it
        inv = 1'b1;
        run_load(0, 0, 0, 0, dc, sh, pl, e1, ed, bcd);
        chk("inv_done_cycle", dc, 32'd29);
        chk("inv_marker_err", {31'd0, ed}, 32'd1);
        inv = 1'b0;
        @(negedge prog_clk);
        chk("inv_err_sticky", {31'd0, marker_err}, 32'd1);
        @(posedge prog_clk); #1;
        run_load(0, 0, 0, 0, dc, sh, pl, e1, ed, bcd);
        chk("clear_err_on_start", {31'd0, e1}, 32'd0);
        chk("clear_marker_err", {31'd0, ed}, 32'd0);
        chk("clear_chain", {12'd0, chain}, 32'h12345);

        // Reset after five payload shifts
        run_load(0, 0, 0, 14, dc, sh, pl, e1, ed, bcd);
        chk("rst_bit_count_before", {27'd0, bcd}, 32'd13);
        chk("rst_no_done", pl, 32'd0);
        @(negedge prog_clk);
        check_all_zero("after_rst");
        @(posedge prog_clk); #1;
        run_load(0, 0, 0, 0, dc, sh, pl, e1, ed, bcd);
        chk("fresh_done_cycle", dc, 32'd29);
        chk("fresh_marker_err", {31'd0, ed}, 32'd0);
        chk("fresh_chain", {12'd0, chain}, 32'h12345);

        // start pulsed mid-load is ignored
        run_load(0, 0, 12, 0, dc, sh, pl, e1, ed, bcd);
        chk("restart_done_cycle", dc, 32'd29);
        chk("restart_pulses", pl, 32'd1);
        chk("restart_bit_count", {27'd0, bcd}, 32'd28);
        chk("restart_chain", {12'd0, chain}, 32'h12345);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
